// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; NOP and HALT encodings are also used by IF/ID and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

endpackage

// File: rtl/fetch_stage_if.sv
// Pipeline-control and instruction-memory signals of the IF stage, bundled for port grouping.
interface fetch_stage_if;

  logic        hazardStall;
  logic        DMemStall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        imem_err;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] PC_add_2;
  logic [15:0] instrData_out;
  logic        IMemStall;
  logic        fetch_err;
  logic        halted;

  modport master (
    input  hazardStall, DMemStall, redirect, redirect_pc,
    input  imem_data, imem_done, imem_err,
    output imem_rd, imem_addr, PC_add_2, instrData_out, IMemStall, fetch_err, halted
  );

  modport slave (
    output hazardStall, DMemStall, redirect, redirect_pc,
    output imem_data, imem_done, imem_err,
    input  imem_rd, imem_addr, PC_add_2, instrData_out, IMemStall, fetch_err, halted
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch FSM: chooses the next PC source and decodes imem_rd / IMemStall / halted.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    hold_i,
  input  logic    redirect_i,
  input  logic    imemDone_i,
  input  logic    haltFetch_i,
  input  logic    haltHeld_i,
  output pc_sel_e pcSel_o,
  output logic    pendEn_o,
  output logic    holdEn_o,
  output logic    useHold_o,
  output logic    imemRd_o,
  output logic    imemStall_o,
  output logic    halted_o
);

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pcSel_o     = PC_KEEP;
    pendEn_o    = 1'b0;
    holdEn_o    = 1'b0;
    useHold_o   = 1'b0;
    imemRd_o    = 1'b0;
    imemStall_o = 1'b1;
    halted_o    = 1'b0;

    if (rst) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          imemRd_o = 1'b1;
          if (redirect_i) begin
            // An outstanding miss cannot be cancelled, so wait it out in DRAIN.
            if (imemDone_i) begin
              pcSel_o = PC_REDIR;
            end else begin
              pendEn_o = 1'b1;
              state_d  = DRAIN;
            end
          end else if (imemDone_i) begin
            imemStall_o = 1'b0;
            if (hold_i) begin
              holdEn_o = 1'b1;
              state_d  = HOLD;
            end else begin
              pcSel_o = PC_INC;
              if (haltFetch_i) state_d = HALTED;
            end
          end
        end

        HOLD: begin
          if (redirect_i) begin
            pcSel_o = PC_REDIR;
            state_d = FETCH;
          end else begin
            imemStall_o = 1'b0;
            useHold_o   = 1'b1;
            if (!hold_i) begin
              pcSel_o = PC_INC;
              state_d = haltHeld_i ? HALTED : FETCH;
            end
          end
        end

        DRAIN: begin
          imemRd_o = 1'b1;
          if (imemDone_i) begin
            pcSel_o = redirect_i ? PC_REDIR : PC_PEND;
            state_d = FETCH;
          end else if (redirect_i) begin
            pendEn_o = 1'b1;
          end
        end

        HALTED: begin
          halted_o = 1'b1;
          if (redirect_i) begin
            pcSel_o = PC_REDIR;
            state_d = FETCH;
          end
        end

        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: rtl/ff_16b.sv
// 16-bit register with synchronous active-high reset and load enable.
module ff_16b #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  always_ff @(posedge clk) begin
    if (rst)       q_o <= RESET_VAL;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, redirect target and held-instruction registers around the fetch FSM.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = fetch_pkg::NOP_INSTR,
  parameter logic [4:0]  HALT_OPCODE = fetch_pkg::HALT_OPCODE
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] pendPc_q;
  logic [15:0] holdInstr_q;
  logic        fetchErr_q;
  pc_sel_e     pcSel;
  logic        pendEn, holdEn, useHold, imemStall;
  logic        hold, haltFetch, haltHeld, errSet;

  assign hold      = bus.hazardStall | bus.DMemStall;
  assign haltFetch = (bus.imem_data[15:11] == HALT_OPCODE);
  assign haltHeld  = (holdInstr_q[15:11] == HALT_OPCODE);

  fetch_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .redirect_i  (bus.redirect),
    .imemDone_i  (bus.imem_done),
    .haltFetch_i (haltFetch),
    .haltHeld_i  (haltHeld),
    .pcSel_o     (pcSel),
    .pendEn_o    (pendEn),
    .holdEn_o    (holdEn),
    .useHold_o   (useHold),
    .imemRd_o    (bus.imem_rd),
    .imemStall_o (imemStall),
    .halted_o    (bus.halted)
  );

  always_comb begin
    pc_d = pc_q;
    unique case (pcSel)
      PC_INC:   pc_d = pc_q + 16'd2;
      PC_REDIR: pc_d = bus.redirect_pc;
      PC_PEND:  pc_d = pendPc_q;
      default:  pc_d = pc_q;
    endcase
  end

  ff_16b #(.RESET_VAL(RESET_PC)) u_pcReg (
    .clk (clk), .rst (rst), .en_i (1'b1), .d_i (pc_d), .q_o (pc_q)
  );

  ff_16b #(.RESET_VAL(RESET_PC)) u_pendReg (
    .clk (clk), .rst (rst), .en_i (pendEn), .d_i (bus.redirect_pc), .q_o (pendPc_q)
  );

  ff_16b #(.RESET_VAL(16'h0000)) u_holdReg (
    .clk (clk), .rst (rst), .en_i (holdEn), .d_i (bus.imem_data), .q_o (holdInstr_q)
  );

  // Misaligned issue and memory-reported errors both latch until reset.
  assign errSet = (bus.imem_done & bus.imem_err) | (bus.imem_rd & pc_q[0]);

  always_ff @(posedge clk) begin
    if (rst)         fetchErr_q <= 1'b0;
    else if (errSet) fetchErr_q <= 1'b1;
  end

  assign bus.imem_addr     = pc_q;
  assign bus.PC_add_2      = pc_q + 16'd2;
  assign bus.IMemStall     = imemStall;
  assign bus.instrData_out = imemStall ? NOP_INSTR : (useHold ? holdInstr_q : bus.imem_data);
  assign bus.fetch_err     = fetchErr_q;

endmodule
